// File: rtl/soc_bus_node_pkg.sv
// soc_bus_node_pkg
// Shared definitions for the soc_bus_node request/grant interconnect:
//   MAX_PORTS      upper bound on initiator and target counts
//   DEF_*_WIDTH    default bus widths used by the node's parameters
//   slvState_e     per-target transaction state
//   req_t          request record {addr, wdata, be, we} at the default bus widths
//   idxWidth()     index width for an N-entry vector (clog2, minimum 1)
package soc_bus_node_pkg;

  localparam int MAX_PORTS      = 8;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } slvState_e;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic [DEF_DATA_WIDTH-1:0]   wdata;
    logic [DEF_DATA_WIDTH/8-1:0] be;
    logic                        we;
  } req_t;

  // A single-entry vector still needs one index bit to be declarable.
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/soc_bus_node_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_i        request vector
//   accept_i     the current selection was taken; pointer moves past it
//   gnt_o        one-hot selection
//   idx_o        index of the selection
//   valid_o      some request is selected
// The selection is purely combinational from req_i and the pointer, so a
// selection that is not accepted is simply recomputed on the next cycle.
module rr_arbiter
  import soc_bus_node_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_i,
  input  logic                   accept_i,
  output logic [N-1:0]           gnt_o,
  output logic [idxWidth(N)-1:0] idx_o,
  output logic                   valid_o
);

  localparam int IW = idxWidth(N);

  logic [IW-1:0] ptr_q, ptr_d;

  // Two priority passes: first the requests at or above the pointer, then
  // wrap around to the lowest index.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (!valid_o && req_i[c] && (c >= int'(ptr_q))) begin
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
        valid_o  = 1'b1;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (!valid_o && req_i[c]) begin
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
        valid_o  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (valid_o && accept_i) begin
      ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/soc_bus_node.sv
// soc_bus_node
// Request/grant bus node connecting NB_MASTER initiators to NB_SLAVE targets.
// Each address is decoded against runtime inclusive [start, end] ranges (the
// lowest matching target wins), each target is arbitrated round-robin, and
// in-order responses are steered back to the master that was granted.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   m_req_i / m_gnt_o                   per-master request / same-cycle grant
//   m_addr_i, m_wdata_i, m_be_i, m_we_i per-master transaction fields
//   m_rvalid_o, m_rdata_o, m_err_o      per-master response
//   s_req_o, s_addr_o, s_wdata_o,
//   s_be_o, s_we_o                      per-target forwarded request
//   s_gnt_i, s_rvalid_i, s_rdata_i      per-target handshake and response
//   start_addr_i, end_addr_i            per-target address range (quasi-static)
// Build option SOC_BUS_NODE_DECERR_EN: when defined, unmapped requests are
// granted by an internal error responder that answers one cycle later with
// m_err_o=1 and zero data; when undefined they are routed to target 0 and
// m_err_o is tied low.
module soc_bus_node
  import soc_bus_node_pkg::*;
#(
  parameter int NB_MASTER  = 3,
  parameter int NB_SLAVE   = 3,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NB_MASTER-1:0]                    m_req_i,
  output logic [NB_MASTER-1:0]                    m_gnt_o,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]    m_addr_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]    m_wdata_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0]  m_be_i,
  input  logic [NB_MASTER-1:0]                    m_we_i,
  output logic [NB_MASTER-1:0]                    m_rvalid_o,
  output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]    m_rdata_o,
  output logic [NB_MASTER-1:0]                    m_err_o,
  output logic [NB_SLAVE-1:0]                     s_req_o,
  output logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]     s_addr_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]     s_wdata_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0]   s_be_o,
  output logic [NB_SLAVE-1:0]                     s_we_o,
  input  logic [NB_SLAVE-1:0]                     s_gnt_i,
  input  logic [NB_SLAVE-1:0]                     s_rvalid_i,
  input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]     s_rdata_i,
  input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]     start_addr_i,
  input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]     end_addr_i
);

  localparam int MIW = idxWidth(NB_MASTER);
  localparam int SIW = idxWidth(NB_SLAVE);
  localparam int BEW = DATA_WIDTH / 8;

  if (NB_MASTER < 1 || NB_MASTER > MAX_PORTS) begin : g_badMasterCount
    $error("soc_bus_node: NB_MASTER out of range");
  end
  if (NB_SLAVE < 1 || NB_SLAVE > MAX_PORTS) begin : g_badSlaveCount
    $error("soc_bus_node: NB_SLAVE out of range");
  end

  logic [NB_MASTER-1:0]               outstanding_q, outstanding_d;
  logic [NB_MASTER-1:0]               eligible;
  logic [NB_MASTER-1:0]               mapped;
  logic [NB_MASTER-1:0][SIW-1:0]      tgtIdx;
  logic [NB_SLAVE-1:0][NB_MASTER-1:0] slvReq;
  logic [NB_SLAVE-1:0][NB_MASTER-1:0] slvGnt;
  logic [NB_SLAVE-1:0]                respValid;
  logic [NB_SLAVE-1:0][MIW-1:0]       respIdx;

  // A master with a transaction in flight may only issue again in the cycle
  // its response is returned.
  assign eligible = ~outstanding_q | m_rvalid_o;

  // Scan targets from highest to lowest so the lowest matching index wins.
  always_comb begin
    tgtIdx = '0;
    mapped = '0;
    for (int m = 0; m < NB_MASTER; m++) begin
      for (int s = NB_SLAVE - 1; s >= 0; s--) begin
        if ((m_addr_i[m] >= start_addr_i[s]) && (m_addr_i[m] <= end_addr_i[s])) begin
          mapped[m] = 1'b1;
          tgtIdx[m] = SIW'(s);
        end
      end
    end
  end

  always_comb begin
    slvReq = '0;
    for (int m = 0; m < NB_MASTER; m++) begin
      for (int s = 0; s < NB_SLAVE; s++) begin
        if (m_req_i[m] && eligible[m]) begin
`ifdef SOC_BUS_NODE_DECERR_EN
          if (mapped[m] && (tgtIdx[m] == SIW'(s))) begin
            slvReq[s][m] = 1'b1;
          end
`else
          if ((mapped[m] && (tgtIdx[m] == SIW'(s))) || (!mapped[m] && (s == 0))) begin
            slvReq[s][m] = 1'b1;
          end
`endif
        end
      end
    end
  end

  for (genvar s = 0; s < NB_SLAVE; s++) begin : g_slave
    slvState_e              state_q, state_d;
    logic [MIW-1:0]         gidx_q, gidx_d;
    logic                   canIssue;
    logic                   arbValid;
    logic                   accept;
    logic [NB_MASTER-1:0]   arbGnt;
    logic [MIW-1:0]         arbIdx;
    logic [ADDR_WIDTH-1:0]  selAddr;
    logic [DATA_WIDTH-1:0]  selWdata;
    logic [BEW-1:0]         selBe;
    logic                   selWe;

    // The response cycle doubles as an idle cycle, allowing back-to-back
    // transactions on a target that answers one cycle after grant.
    assign canIssue = (state_q == IDLE) || s_rvalid_i[s];
    assign accept   = arbValid && s_gnt_i[s];

    rr_arbiter #(
      .N(NB_MASTER)
    ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (slvReq[s] & {NB_MASTER{canIssue}}),
      .accept_i (s_gnt_i[s]),
      .gnt_o    (arbGnt),
      .idx_o    (arbIdx),
      .valid_o  (arbValid)
    );

    // One-hot OR-mux keeps the forwarded fields at zero when nothing is
    // selected.
    always_comb begin
      selAddr  = '0;
      selWdata = '0;
      selBe    = '0;
      selWe    = 1'b0;
      for (int m = 0; m < NB_MASTER; m++) begin
        if (arbGnt[m]) begin
          selAddr  = selAddr  | m_addr_i[m];
          selWdata = selWdata | m_wdata_i[m];
          selBe    = selBe    | m_be_i[m];
          selWe    = selWe    | m_we_i[m];
        end
      end
    end

    assign s_req_o[s]   = arbValid;
    assign s_addr_o[s]  = selAddr;
    assign s_wdata_o[s] = selWdata;
    assign s_be_o[s]    = selBe;
    assign s_we_o[s]    = selWe;

    assign slvGnt[s]    = arbGnt & {NB_MASTER{s_gnt_i[s]}};
    assign respValid[s] = (state_q == WAIT_RESP) && s_rvalid_i[s];
    assign respIdx[s]   = gidx_q;

    always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = WAIT_RESP;
            gidx_d  = arbIdx;
          end
        end
        WAIT_RESP: begin
          if (s_rvalid_i[s]) begin
            if (accept) begin
              gidx_d = arbIdx;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        gidx_q  <= '0;
      end else begin
        state_q <= state_d;
        gidx_q  <= gidx_d;
      end
    end
  end

`ifdef SOC_BUS_NODE_DECERR_EN
  logic [NB_MASTER-1:0] errGnt;
  logic                 errPend_q, errPend_d;
  logic [MIW-1:0]       errIdx_q, errIdx_d;

  // Internal error responder: accepts at most one unmapped request per
  // cycle, lowest master first, and answers on the following cycle.
  always_comb begin
    errGnt    = '0;
    errPend_d = 1'b0;
    errIdx_d  = errIdx_q;
    for (int m = 0; m < NB_MASTER; m++) begin
      if (!errPend_d && m_req_i[m] && eligible[m] && !mapped[m]) begin
        errGnt[m] = 1'b1;
        errPend_d = 1'b1;
        errIdx_d  = MIW'(m);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errPend_q <= 1'b0;
      errIdx_q  <= '0;
    end else begin
      errPend_q <= errPend_d;
      errIdx_q  <= errIdx_d;
    end
  end
`endif

  always_comb begin
    m_gnt_o = '0;
    for (int s = 0; s < NB_SLAVE; s++) begin
      m_gnt_o = m_gnt_o | slvGnt[s];
    end
`ifdef SOC_BUS_NODE_DECERR_EN
    m_gnt_o = m_gnt_o | errGnt;
`endif
  end

  // Only one transaction per master can be in flight, so at most one source
  // ever targets a given master in a cycle.
  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    for (int s = 0; s < NB_SLAVE; s++) begin
      for (int m = 0; m < NB_MASTER; m++) begin
        if (respValid[s] && (respIdx[s] == MIW'(m))) begin
          m_rvalid_o[m] = 1'b1;
          m_rdata_o[m]  = s_rdata_i[s];
        end
      end
    end
`ifdef SOC_BUS_NODE_DECERR_EN
    for (int m = 0; m < NB_MASTER; m++) begin
      if (errPend_q && (errIdx_q == MIW'(m))) begin
        m_rvalid_o[m] = 1'b1;
        m_err_o[m]    = 1'b1;
      end
    end
`endif
  end

  // A grant in the response cycle wins over the clear.
  assign outstanding_d = m_gnt_o | (outstanding_q & ~m_rvalid_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

endmodule
